// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with registered read data, occupancy-decoded status flags
// and one-cycle error pulses for rejected strobes.
module sync_fifo_core #(
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ALM_FULL_TH  = 14,
    parameter int unsigned ALM_EMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wren,
    input  logic [DATA_W-1:0]          i_wrdata,
    input  logic                       i_rden,
    output logic [DATA_W-1:0]          o_rddata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_alm_full,
    output logic                       o_alm_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_wr_err,
    output logic                       o_rd_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              rd_ok;
    logic              wr_ok;

    // Status is a pure decode of the registered occupancy
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign o_full      = full;
    assign o_empty     = empty;
    assign o_alm_full  = (count >= CNT_W'(ALM_FULL_TH));
    assign o_alm_empty = (count <= CNT_W'(ALM_EMPTY_TH));
    assign o_count     = count;

    // A simultaneous read frees a slot, so a write while full is still accepted
    assign rd_ok = i_rden & ~empty;
    assign wr_ok = i_wren & (~full | rd_ok);

    // Storage array carries no reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= i_wrdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            o_rddata <= '0;
            o_wr_err <= 1'b0;
            o_rd_err <= 1'b0;
        end else begin
            o_wr_err <= i_wren & ~wr_ok;
            o_rd_err <= i_rden & ~rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + ADDR_W'(1);
                o_rddata <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed bench for sync_fifo_core: a queue scoreboard predicts read data,
// occupancy, flags and error pulses for every cycle.
module tb_sync_fifo_core;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_wren = 1'b0;
    logic [DATA_W-1:0] i_wrdata = '0;
    logic              i_rden = 1'b0;
    logic [DATA_W-1:0] o_rddata;
    logic              o_full;
    logic              o_empty;
    logic              o_alm_full;
    logic              o_alm_empty;
    logic [4:0]        o_count;
    logic              o_wr_err;
    logic              o_rd_err;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] exp_rd = '0;
    logic              exp_wr_err = 1'b0;
    logic              exp_rd_err = 1'b0;

    sync_fifo_core #(
        .DATA_W(128), .DEPTH(16), .ALM_FULL_TH(14), .ALM_EMPTY_TH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .i_wren(i_wren), .i_wrdata(i_wrdata), .i_rden(i_rden),
        .o_rddata(o_rddata), .o_full(o_full), .o_empty(o_empty),
        .o_alm_full(o_alm_full), .o_alm_empty(o_alm_empty), .o_count(o_count),
        .o_wr_err(o_wr_err), .o_rd_err(o_rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = sb.size();
        check({tag, ".rddata"},    o_rddata, exp_rd);
        check({tag, ".count"},     DATA_W'(o_count), DATA_W'(n));
        check({tag, ".full"},      DATA_W'(o_full), DATA_W'(n == DEPTH));
        check({tag, ".empty"},     DATA_W'(o_empty), DATA_W'(n == 0));
        check({tag, ".alm_full"},  DATA_W'(o_alm_full), DATA_W'(n >= 14));
        check({tag, ".alm_empty"}, DATA_W'(o_alm_empty), DATA_W'(n <= 2));
        check({tag, ".wr_err"},    DATA_W'(o_wr_err), DATA_W'(exp_wr_err));
        check({tag, ".rd_err"},    DATA_W'(o_rd_err), DATA_W'(exp_rd_err));
    endtask

    // Predict the edge from the pre-edge scoreboard state, then clock and compare
    task automatic cyc(input string tag, input logic we, input logic [DATA_W-1:0] wd, input logic re);
        logic rd_ok;
        logic wr_ok;
        rd_ok = re && (sb.size() != 0);
        wr_ok = we && ((sb.size() != DEPTH) || rd_ok);
        if (rd_ok) exp_rd = sb.pop_front();
        if (wr_ok) sb.push_back(wd);
        exp_wr_err = we && !wr_ok;
        exp_rd_err = re && !rd_ok;
        i_wren   = we;
        i_wrdata = wd;
        i_rden   = re;
        @(posedge clk);
        #1;
        i_wren = 1'b0;
        i_rden = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        sb.delete();
        exp_rd     = '0;
        exp_wr_err = 1'b0;
        exp_rd_err = 1'b0;
    endtask

    initial begin
        // 1. reset state, then idle with no strobes
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;
        cyc("idle", 1'b0, '0, 1'b0);

        // 2. fill 0x1..0x10, then overflow attempt
        for (int i = 1; i <= 16; i++) cyc("fill", 1'b1, DATA_W'(i), 1'b0);
        check("fill.full_const", DATA_W'(o_full), DATA_W'(1));
        cyc("overflow", 1'b1, DATA_W'(128'hDEAD), 1'b0);
        check("overflow.wr_err_const", DATA_W'(o_wr_err), DATA_W'(1));
        cyc("overflow_clear", 1'b0, '0, 1'b0);

        // 3. drain in order, then underflow attempt
        for (int i = 1; i <= 16; i++) cyc("drain", 1'b0, '0, 1'b1);
        cyc("underflow", 1'b0, '0, 1'b1);
        check("underflow.rddata_hold", o_rddata, DATA_W'(128'h10));
        check("underflow.rd_err_const", DATA_W'(o_rd_err), DATA_W'(1));

        // 4. simultaneous read+write while full reuses the freed slot
        for (int i = 1; i <= 16; i++) cyc("refill", 1'b1, DATA_W'(32'h100 + i), 1'b0);
        cyc("full_rw", 1'b1, DATA_W'(128'hAA), 1'b1);
        check("full_rw.count_const", DATA_W'(o_count), DATA_W'(16));
        check("full_rw.oldest", o_rddata, DATA_W'(128'h101));
        for (int i = 0; i < 16; i++) cyc("drain_aa", 1'b0, '0, 1'b1);
        check("drain_aa.last", o_rddata, DATA_W'(128'hAA));

        // 5. simultaneous read+write while empty: no bypass
        cyc("empty_rw", 1'b1, DATA_W'(128'h55), 1'b1);
        check("empty_rw.rd_err_const", DATA_W'(o_rd_err), DATA_W'(1));
        check("empty_rw.count_const", DATA_W'(o_count), DATA_W'(1));
        cyc("empty_rw_read", 1'b0, '0, 1'b1);
        check("empty_rw.data_const", o_rddata, DATA_W'(128'h55));

        // 6. interleaved traffic wrapping pointers, with a reset mid-stream
        for (int i = 0; i < 40; i++) begin
            cyc("stream", 1'b1, DATA_W'(32'h1000 + i), (i % 3) != 0);
            if (i == 25) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                check_all("midreset");
                @(negedge clk);
                reset = 1'b0;
            end
        end
        while (sb.size() != 0) cyc("stream_drain", 1'b0, '0, 1'b1);
        cyc("stream_under", 1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
